chip8_timers: RTL

- CHIP-8 delay timer (DT) and sound timer (ST) unit.
- Sits directly downstream of the clock divider: the divider's 60 Hz output enters as a plain data input (tick_clk) and is synchronised and edge-detected inside the clk_in domain. It is never used as a clock.
- Gives the CPU load/readback access to DT and ST, and drives the buzzer tone while ST is non-zero.

---
 rtl/chip8_timers.sv | 124 ++++++++++++
 1 files changed

// File: rtl/chip8_timers.sv
// rtl/chip8_timers.sv - CHIP-8 delay/sound timers with tick synchroniser and buzzer tone
//
// Purpose: holds the CHIP-8 delay timer (DT) and sound timer (ST). Both count
// down at 60 Hz and stop at 0. The tone generator drives the buzzer while ST is
// non-zero. The 60 Hz divider output is sampled as data in the clk_in domain and
// is never used as a clock.
//
// Ports:
//   clk_in    - system clock; all flops update on its rising edge
//   rst       - asynchronous, active-high reset
//   tick_clk  - 60 Hz level from the clock divider
//   dt_we     - load DT from wdata
//   st_we     - load ST from wdata
//   wdata     - load value for DT/ST
//   dt_value  - current DT, registered
//   st_value  - current ST, registered
//   tick      - one-cycle pulse per detected tick_clk rising edge
//   sound_on  - high while st_value != 0
//   buzzer    - registered square-wave tone
module chip8_timers #(
  parameter int SYNC_STAGES = 2,
  parameter int TONE_DIV    = 4
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick_clk,
  input  logic       dt_we,
  input  logic       st_we,
  input  logic [7:0] wdata,
  output logic [7:0] dt_value,
  output logic [7:0] st_value,
  output logic       tick,
  output logic       sound_on,
  output logic       buzzer
);

  localparam int CW = $clog2(TONE_DIV);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q;
  logic [7:0]             dt_q, dt_d;
  logic [7:0]             st_q, st_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   buzz_q, buzz_d;

  // Shift tick_clk through the synchroniser chain, stage 0 first.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = tick_clk;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Chain and edge history reset to 1: a level already high at reset release
  // must not look like a fresh rising edge.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick = sync_q[SYNC_STAGES-1] & ~hist_q;

  // A write wins over a coincident tick; decrement stops at 0.
  always_comb begin
    dt_d = dt_q;
    if (dt_we) begin
      dt_d = wdata;
    end else if (tick && (dt_q != 8'd0)) begin
      dt_d = dt_q - 8'd1;
    end
  end

  always_comb begin
    st_d = st_q;
    if (st_we) begin
      st_d = wdata;
    end else if (tick && (st_q != 8'd0)) begin
      st_d = st_q - 8'd1;
    end
  end

  assign sound_on = (st_q != 8'd0);

  // Tone: counter runs 0..TONE_DIV-1 and toggles the buzzer on wrap, giving a
  // 2*TONE_DIV period. Silence clears both so every tone starts in phase.
  always_comb begin
    cnt_d  = cnt_q;
    buzz_d = buzz_q;
    if (!sound_on) begin
      cnt_d  = '0;
      buzz_d = 1'b0;
    end else if (cnt_q == CW'(TONE_DIV - 1)) begin
      cnt_d  = '0;
      buzz_d = ~buzz_q;
    end else begin
      cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      dt_q   <= 8'd0;
      st_q   <= 8'd0;
      cnt_q  <= '0;
      buzz_q <= 1'b0;
    end else begin
      dt_q   <= dt_d;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      buzz_q <= buzz_d;
    end
  end

  assign dt_value = dt_q;
  assign st_value = st_q;
  assign buzzer   = buzz_q;

endmodule
